phy_reset_seq: RTL and testbench
================================

# phy_reset_seq

Parametrised multi-channel PHY reset sequencer: the generalised successor of the single free-running power-up counter that holds an Ethernet PHY in reset. On power-up it holds every channel's active-low reset for a programmable time, releases channels one at a time with a programmable stagger, waits a settle time, then reports done. Afterwards, software or a VIO can re-reset any subset of channels without disturbing the others. It sits in the top level between the clock wizard / reset bridge and the external PHY and SerDes reset pins.

## Interface
- NUM_CH, 2: number of PHY reset outputs (1..16).
- CNT_W, 16: width of the shared delay counter.
- ASSERT_CYCLES, 65535: reset-low hold time, in clk cycles.
- STAGGER_CYCLES, 256: cycles between successive channel releases.
- SETTLE_CYCLES, 1024: cycles from the last release to done.
- Each delay parameter must be ≥1 and < 2^CNT_W.

Ports:
- clk  in  1: sequencer clock.
- rst  in  1: asynchronous, active-high reset.
- i_req  in  1: single-cycle re-reset request.
- i_sel  in  NUM_CH: channel mask, sampled together with i_req.
- o_phy_resetn  out  NUM_CH: active-low PHY resets, registered.
- o_done  out  NUM_CH: channel out of reset and settled.
- o_busy  out  1: sequence in progress.
- o_req_drop  out  1: one-cycle pulse when a request is refused.

## Operation
- Internal state: a CNT_W counter; a latched channel mask `act`; a release index.
- FSM states: ASSERT, RELEASE, SETTLE, DONE.
- Reset values:
  - State is ASSERT, `act` is all-ones, counter is 0.
  - o_phy_resetn = 0, o_done = 0, o_busy = 1, o_req_drop = 0.
- ASSERT: channels in `act` are held low. The counter counts up to ASSERT_CYCLES, then the FSM goes to RELEASE with the counter at 0.
- RELEASE:
  - Channels in `act` are released in ascending index order. Unselected indices are skipped with no gap.
  - The first selected channel is released on entry. Each next selected channel follows STAGGER_CYCLES later.
  - After the last selected channel is released, the FSM goes to SETTLE.
- SETTLE: after SETTLE_CYCLES, o_done is set for all channels in `act`, o_busy is cleared, and the FSM goes to DONE.
- DONE, on i_req=1 with i_sel≠0:
  - `act` ← i_sel.
  - Selected channels: o_phy_resetn = 0 and o_done = 0.
  - The FSM goes to ASSERT and o_busy = 1.
  - Unselected channels keep their resetn and done values.
- i_req=1 with i_sel=0 is a no-op: no drop pulse, no state change.
- i_req=1 while o_busy=1 (any state other than DONE) is ignored. o_req_drop pulses for one cycle. Sequence timing is unaffected.
- Channels outside `act` never change during a sequence.
- rst asserted mid-sequence restarts the full power-up sequence with all channels selected.

## Timing
- Edge t=1 is the first rising clk edge after rst falls.
- Power-up, after edge t:
  - The k-th channel in `act` (k=0..M-1, M = popcount) goes high at t = ASSERT_CYCLES + k·STAGGER_CYCLES.
  - o_done and o_busy update at t = ASSERT_CYCLES + (M-1)·STAGGER_CYCLES + SETTLE_CYCLES.
- Accepted request at edge E:
  - Selected resets go low and done bits clear after edge E (1-cycle latency).
  - Release and done times follow the same formulas, with t counted from E.
- A request at the same edge that sets o_done counts as busy: it is refused and drop pulses.
- All outputs are registered. No combinational path from inputs to outputs.
- The counter never wraps: it is cleared on every state transition.

## Test plan
Parameters for all scenarios: NUM_CH=4, CNT_W=8, ASSERT=10, STAGGER=3, SETTLE=5.

- Power-up -> resetn[0..3] rise after edges 10/13/16/19; o_done=4'hF and o_busy=0 after edge 24.
- In DONE, i_req with i_sel=4'b1010 at edge E:
  - resetn[1] and resetn[3] low after E; resetn[1] high at E+10, resetn[3] high at E+13.
  - done[1] and done[3] set at E+18.
  - Channels 0 and 2 stay high with done=1 throughout.
- i_req at edge 12 of power-up -> o_req_drop high for exactly one cycle; all release and done edges unchanged from the first scenario.
- i_req with i_sel=0 in DONE -> no output change, o_req_drop stays 0.
- rst pulsed at edge 15 of power-up (resetn[0] already high) -> all outputs return to their reset values immediately; the full sequence repeats from the new t=1.
- i_req at the edge where o_done is set (edge 24) -> refused with a drop pulse; a request at edge 25 is accepted.

Source files
------------

// File: rtl/phy_reset_seq.sv
// phy_reset_seq
//
// Multi-channel PHY reset sequencer. After power-up (or rst) every channel's
// active-low reset is held for ASSERT_CYCLES. The channels are then released
// one at a time in ascending index order, STAGGER_CYCLES apart. After a
// further SETTLE_CYCLES the released channels report done. Once the
// sequencer is idle, a request can re-run the same sequence on any subset
// of channels. Channels outside the subset are left untouched.
//
// Ports
//   clk          in   sequencer clock
//   rst          in   asynchronous active-high reset; restarts the power-up sequence
//   i_req        in   single-cycle re-reset request
//   i_sel        in   channel mask, sampled together with i_req
//   o_phy_resetn out  active-low PHY resets, one per channel (registered)
//   o_done       out  per-channel "out of reset and settled" (registered)
//   o_busy       out  a sequence is in progress (registered)
//   o_req_drop   out  one-cycle pulse when a request arrives while busy (registered)

module phy_reset_seq #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned ASSERT_CYCLES  = 65535,
    parameter int unsigned STAGGER_CYCLES = 256,
    parameter int unsigned SETTLE_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [NUM_CH-1:0] i_sel,
    output logic [NUM_CH-1:0] o_phy_resetn,
    output logic [NUM_CH-1:0] o_done,
    output logic              o_busy,
    output logic              o_req_drop
);

    // Terminal counts. A phase ends on the edge where the counter holds N-1,
    // so each phase lasts exactly N edges.
    localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StAssert,
        StRelease,
        StSettle,
        StDone
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] act_q;   // channels taking part in the current sequence
    logic [NUM_CH-1:0] pend_q;  // channels of act_q not yet released

    // Lowest set bit of a mask. This picks the next channel to release, so
    // unselected indices are skipped with no gap.
    logic [NUM_CH-1:0] act_low;
    logic [NUM_CH-1:0] act_rest;
    logic [NUM_CH-1:0] pend_low;
    logic [NUM_CH-1:0] pend_rest;
    logic              req_valid;

    always_comb begin
        act_low   = act_q & (~act_q + NUM_CH'(1));
        act_rest  = act_q & ~act_low;
        pend_low  = pend_q & (~pend_q + NUM_CH'(1));
        pend_rest = pend_q & ~pend_low;
        // An empty mask is a no-op everywhere, so it is never dropped either.
        req_valid = i_req && (|i_sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StAssert;
            cnt_q        <= '0;
            act_q        <= '1;
            pend_q       <= '0;
            o_phy_resetn <= '0;
            o_done       <= '0;
            o_busy       <= 1'b1;
            o_req_drop   <= 1'b0;
        end else begin
            // While busy (anything but StDone), the request is refused.
            // A request on the edge that enters StDone is refused too.
            o_req_drop <= req_valid && (state_q != StDone);

            unique case (state_q)
                StAssert: begin
                    if (cnt_q == ASSERT_LAST) begin
                        // The first selected channel is released on entry to RELEASE.
                        cnt_q        <= '0;
                        o_phy_resetn <= o_phy_resetn | act_low;
                        pend_q       <= act_rest;
                        state_q      <= (act_rest == '0) ? StSettle : StRelease;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                StRelease: begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_q        <= '0;
                        o_phy_resetn <= o_phy_resetn | pend_low;
                        pend_q       <= pend_rest;
                        if (pend_rest == '0) begin
                            state_q <= StSettle;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                StSettle: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        o_done  <= o_done | act_q;
                        o_busy  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                StDone: begin
                    if (req_valid) begin
                        // Only the selected channels restart; the others keep their values.
                        act_q        <= i_sel;
                        o_phy_resetn <= o_phy_resetn & ~i_sel;
                        o_done       <= o_done & ~i_sel;
                        o_busy       <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= StAssert;
                    end
                end

                default: state_q <= StAssert;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_reset_seq.sv
// tb_phy_reset_seq
//
// Self-checking bench for phy_reset_seq with NUM_CH=4, CNT_W=8, ASSERT=10,
// STAGGER=3, SETTLE=5. When stimulus is scheduled, the expected outputs for
// every edge are computed from the release/done timing formulas. They are
// queued and then popped and compared one per clock edge, 1 time unit after
// the edge.

module tb_phy_reset_seq;

    localparam int NCH = 4;
    localparam int A   = 10;
    localparam int S   = 3;
    localparam int SE  = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req = 1'b0;
    logic [NCH-1:0] sel = '0;
    logic [NCH-1:0] phy_resetn;
    logic [NCH-1:0] done;
    logic           busy;
    logic           req_drop;

    phy_reset_seq #(
        .NUM_CH        (NCH),
        .CNT_W         (8),
        .ASSERT_CYCLES (A),
        .STAGGER_CYCLES(S),
        .SETTLE_CYCLES (SE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_sel       (sel),
        .o_phy_resetn(phy_resetn),
        .o_done      (done),
        .o_busy      (busy),
        .o_req_drop  (req_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] rstn;
        logic [NCH-1:0] dn;
        logic           bsy;
        logic           drp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // Queue the expected outputs after edges e0+jlo .. e0+jhi. The sequence
    // on mask act starts at edge e0, and j counts edges from e0.
    task automatic push_seq(input int e0, input int jlo, input int jhi, input logic [NCH-1:0] act,
                            input logic [NCH-1:0] base_rstn, input logic [NCH-1:0] base_done,
                            input int drop_at);
        int m;
        int done_t;
        m      = $countones(act);
        done_t = A + (m - 1) * S + SE;
        for (int j = jlo; j <= jhi; j++) begin
            exp_t it;
            int   k;
            k      = 0;
            it.cyc = e0 + j;
            for (int i = 0; i < NCH; i++) begin
                if (act[i]) begin
                    it.rstn[i] = (j >= A + k * S);
                    it.dn[i]   = (j >= done_t);
                    k++;
                end else begin
                    it.rstn[i] = base_rstn[i];
                    it.dn[i]   = base_done[i];
                end
            end
            it.bsy = (j < done_t);
            it.drp = (j == drop_at);
            sb.push_back(it);
        end
    endtask

    // Queue n idle edges on which the outputs must not move.
    task automatic push_hold(input int e0, input int n, input logic [NCH-1:0] rstn,
                             input logic [NCH-1:0] dn);
        for (int j = 0; j < n; j++) begin
            exp_t it;
            it.cyc  = e0 + j;
            it.rstn = rstn;
            it.dn   = dn;
            it.bsy  = 1'b0;
            it.drp  = 1'b0;
            sb.push_back(it);
        end
    endtask

    // Drive one edge's inputs, clock it, then compare against the scoreboard head.
    task automatic step(input logic r, input logic [NCH-1:0] s);
        req = r;
        sel = s;
        @(posedge clk);
        #1;
        req = 1'b0;
        sel = '0;
        edge_n++;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            exp_t it;
            it = sb.pop_front();
            check("sb_align", 32'(edge_n), 32'(it.cyc));
            check("phy_resetn", {28'b0, phy_resetn}, {28'b0, it.rstn});
            check("done", {28'b0, done}, {28'b0, it.dn});
            check("busy", {31'b0, busy}, {31'b0, it.bsy});
            check("req_drop", {31'b0, req_drop}, {31'b0, it.drp});
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_resetn"}, {28'b0, phy_resetn}, 32'h0);
        check({pfx, "_done"}, {28'b0, done}, 32'h0);
        check({pfx, "_busy"}, {31'b0, busy}, 32'h1);
        check({pfx, "_drop"}, {31'b0, req_drop}, 32'h0);
    endtask

    initial begin
        // Reset values while rst is held.
        rst = 1'b1;
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst    = 1'b0;
        edge_n = 0;

        // Power-up with a refused request at edge 12; the timing must be unchanged.
        push_seq(0, 1, 30, 4'hF, 4'h0, 4'h0, 12);
        for (int e = 1; e <= 30; e++) step(e == 12, (e == 12) ? 4'hF : 4'h0);

        // Partial re-reset of channels 1 and 3 accepted at edge 31.
        push_seq(31, 0, 25, 4'b1010, 4'hF, 4'hF, -1);
        for (int e = 31; e <= 56; e++) step(e == 31, (e == 31) ? 4'b1010 : 4'h0);

        // Request with an empty mask in DONE is a no-op.
        push_hold(57, 4, 4'hF, 4'hF);
        for (int e = 57; e <= 60; e++) step(e == 57, 4'h0);

        // Fresh power-up, then rst asserted after edge 15 (channel 0 already high).
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        edge_n = 0;
        push_seq(0, 1, 15, 4'hF, 4'h0, 4'h0, -1);
        for (int e = 1; e <= 15; e++) step(1'b0, 4'h0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst    = 1'b0;
        edge_n = 0;

        // Full sequence repeats. A request on the done edge (24) is refused,
        // and the request at edge 25 is accepted for channel 0 only.
        push_seq(0, 1, 24, 4'hF, 4'h0, 4'h0, 24);
        push_seq(25, 0, 20, 4'b0001, 4'hF, 4'hF, -1);
        for (int e = 1; e <= 45; e++) begin
            step((e == 24) || (e == 25), (e == 24) ? 4'hF : ((e == 25) ? 4'b0001 : 4'h0));
        end

        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
